spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_pkg.sv | 33 +++
 rtl/spi_reg_ctrl_if.sv | 12 +
 rtl/cs_sync_edge.sv | 30 +++
 rtl/spi_reg_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller: frame layout, register
// addresses, FSM states and the reply word for unmapped addresses.
package spi_reg_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 24;

  localparam logic [ADDR_W-1:0] ADDR_ID      = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_ODO_L   = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_ODO_R   = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_L   = 7'h10;
  localparam logic [ADDR_W-1:0] ADDR_PWM_R   = 7'h11;
  localparam logic [ADDR_W-1:0] ADDR_FLAGS   = 7'h12;
  localparam logic [ADDR_W-1:0] ADDR_ODO_CLR = 7'h13;

  localparam logic [WORD_W-1:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_EXEC,
    ST_LOAD
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Word-level link between the SPI shift register and the register controller.
interface spi_reg_ctrl_if;
  import spi_reg_pkg::*;

  logic              spi_cs;
  logic [WORD_W-1:0] spi_rx_word;
  logic [WORD_W-1:0] spi_tx_word;

  modport master (output spi_cs, output spi_rx_word, input spi_tx_word);
  modport slave  (input spi_cs, input spi_rx_word, output spi_tx_word);

endinterface

// File: rtl/cs_sync_edge.sv
// Two-flop synchronizer for the raw chip select plus rise/fall edge detect.
module cs_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic cs_raw_i,
  output logic cs_sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  // Reset high so a deasserted cs after reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= cs_raw_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign cs_sync_o = s2_q;
  assign rise_o    = s2_q & ~s3_q;
  assign fall_o    = ~s2_q & s3_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register controller behind an SPI slave: each frame is decoded after cs rises,
// writes take effect in EXEC and the reply for the next frame is loaded in LOAD.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned       WDOG_CYCLES = 5_000_000,
  parameter logic [WORD_W-1:0] ID_WORD     = 32'h4D42_0001
) (
  input  logic          clk,
  input  logic          reset_n,
  spi_reg_ctrl_if.slave spi,
  input  logic [31:0]   odo_l,
  input  logic [31:0]   odo_r,
  input  logic [15:0]   status_in,
  output logic [15:0]   pwm_l,
  output logic [15:0]   pwm_r,
  output logic [7:0]    ctrl_flags,
  output logic          odo_clear,
  output logic          wdog_expired,
  output logic [15:0]   frame_cnt
);

  // state      | meaning
  // ST_IDLE    | waiting for a synchronized cs rising edge
  // ST_CAPTURE | latch the received frame
  // ST_EXEC    | apply write, count frame, kick watchdog
  // ST_LOAD    | load reply word unless cs has dropped

  localparam int                WD_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WDOG_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(WDOG_CYCLES);

  logic              cs_s, cs_rise, cs_fall, cs_lost;
  state_e            state_q, state_d;
  logic              capture_en, exec_en, load_en;
  frame_t            frame_q, frame_d;
  logic [15:0]       pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        flags_q, flags_d;
  logic              odo_clear_q, odo_clear_d;
  logic              expired_q, expired_d;
  logic              abort_q, abort_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [WORD_W-1:0] tx_q, tx_d, rd_word;
  logic              unused_data;

  cs_sync_edge u_cs_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs_raw_i  (spi.spi_cs),
    .cs_sync_o (cs_s),
    .rise_o    (cs_rise),
    .fall_o    (cs_fall)
  );

  // Any cs drop since the frame ended cancels the reply load.
  assign cs_lost = abort_q | cs_fall | ~cs_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cs_rise) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_EXEC;
      ST_EXEC:    state_d = cs_lost ? ST_IDLE : ST_LOAD;
      ST_LOAD:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture_en = (state_q == ST_CAPTURE);
    exec_en    = (state_q == ST_EXEC);
    load_en    = (state_q == ST_LOAD) && !cs_lost;
  end

  always_comb begin
    case (frame_q.addr)
      ADDR_ID:     rd_word = ID_WORD;
      ADDR_ODO_L:  rd_word = odo_l;
      ADDR_ODO_R:  rd_word = odo_r;
      ADDR_STATUS: rd_word = {frame_cnt_q, status_in};
      ADDR_PWM_L:  rd_word = {16'h0, pwm_l_q};
      ADDR_PWM_R:  rd_word = {16'h0, pwm_r_q};
      ADDR_FLAGS:  rd_word = {24'h0, flags_q};
      default:     rd_word = ERR_WORD;
    endcase
  end

  always_comb begin
    frame_d     = frame_q;
    pwm_l_d     = pwm_l_q;
    pwm_r_d     = pwm_r_q;
    flags_d     = flags_q;
    frame_cnt_d = frame_cnt_q;
    odo_clear_d = 1'b0;
    expired_d   = expired_q;
    tx_d        = tx_q;
    abort_d     = (state_q == ST_IDLE) ? 1'b0 : (abort_q | cs_fall);
    wd_d        = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

    if (wd_q == WD_LAST) begin
      expired_d = 1'b1;
      pwm_l_d   = '0;
      pwm_r_d   = '0;
    end

    if (capture_en) frame_d = spi.spi_rx_word;

    // EXEC overrides the watchdog, so a coinciding pwm write wins.
    if (exec_en) begin
      wd_d        = '0;
      expired_d   = 1'b0;
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (frame_q.wr) begin
        case (frame_q.addr)
          ADDR_PWM_L:   pwm_l_d     = frame_q.data[15:0];
          ADDR_PWM_R:   pwm_r_d     = frame_q.data[15:0];
          ADDR_FLAGS:   flags_d     = frame_q.data[7:0];
          ADDR_ODO_CLR: odo_clear_d = 1'b1;
          default:      ;
        endcase
      end
    end

    if (load_en) tx_d = rd_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q     <= '0;
      pwm_l_q     <= '0;
      pwm_r_q     <= '0;
      flags_q     <= '0;
      frame_cnt_q <= '0;
      odo_clear_q <= 1'b0;
      expired_q   <= 1'b0;
      abort_q     <= 1'b0;
      wd_q        <= '0;
      tx_q        <= ID_WORD;
    end else begin
      frame_q     <= frame_d;
      pwm_l_q     <= pwm_l_d;
      pwm_r_q     <= pwm_r_d;
      flags_q     <= flags_d;
      frame_cnt_q <= frame_cnt_d;
      odo_clear_q <= odo_clear_d;
      expired_q   <= expired_d;
      abort_q     <= abort_d;
      wd_q        <= wd_d;
      tx_q        <= tx_d;
    end
  end

  assign unused_data     = ^frame_q.data[23:16];
  assign spi.spi_tx_word = tx_q;
  assign pwm_l           = pwm_l_q;
  assign pwm_r           = pwm_r_q;
  assign ctrl_flags      = flags_q;
  assign odo_clear       = odo_clear_q;
  assign wdog_expired    = expired_q;
  assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: table of frames with expected register state, plus
// hand-written cs-drop, watchdog and mid-frame reset sequences.
module tb_spi_reg_ctrl;
  import spi_reg_pkg::*;

  localparam int unsigned WDOG = 100;
  localparam logic [31:0] ID   = 32'h4D42_0001;
  localparam logic [31:0] ODOL = 32'h0000_ABCD;
  localparam logic [31:0] ODOR = 32'h1357_2468;
  localparam logic [15:0] STAT = 16'h5AA5;
  localparam int          NVEC = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] odo_l, odo_r;
  logic [15:0] status_in;
  logic [15:0] pwm_l, pwm_r, frame_cnt;
  logic [7:0]  ctrl_flags;
  logic        odo_clear, wdog_expired;

  spi_reg_ctrl_if spi_if ();

  spi_reg_ctrl #(.WDOG_CYCLES(WDOG), .ID_WORD(ID)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi          (spi_if),
    .odo_l        (odo_l),
    .odo_r        (odo_r),
    .status_in    (status_in),
    .pwm_l        (pwm_l),
    .pwm_r        (pwm_r),
    .ctrl_flags   (ctrl_flags),
    .odo_clear    (odo_clear),
    .wdog_expired (wdog_expired),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rx;
    logic [31:0] tx;
    logic [15:0] pl;
    logic [15:0] pr;
    logic [7:0]  fl;
    logic [15:0] fc;
    logic        oc;
  } vec_t;

  vec_t vec[NVEC];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   oc_hits, oc_pos;

  function automatic vec_t mk(input logic [31:0] rx, input logic [31:0] tx,
                              input logic [15:0] pl, input logic [15:0] pr,
                              input logic [7:0] fl, input logic [15:0] fc,
                              input logic oc);
    vec_t v;
    v.rx = rx; v.tx = tx; v.pl = pl; v.pr = pr; v.fl = fl; v.fc = fc; v.oc = oc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // cs is raised at a falling edge; odo_clear from EXEC shows after the 5th rising edge.
  task automatic send_frame(input logic [31:0] word, input int drop_at);
    @(negedge clk);
    spi_if.spi_cs      = 1'b0;
    spi_if.spi_rx_word = word;
    repeat (3) @(negedge clk);
    spi_if.spi_cs = 1'b1;
    oc_hits = 0;
    oc_pos  = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (odo_clear) begin
        oc_hits++;
        oc_pos = k;
      end
      if (k == drop_at) spi_if.spi_cs = 1'b0;
    end
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] tx, input logic [15:0] pl,
                          input logic [15:0] pr, input logic [7:0] fl, input logic [15:0] fc);
    chk({tag, " tx"},    spi_if.spi_tx_word, tx);
    chk({tag, " pwm_l"}, 32'(pwm_l), 32'(pl));
    chk({tag, " pwm_r"}, 32'(pwm_r), 32'(pr));
    chk({tag, " flags"}, 32'(ctrl_flags), 32'(fl));
    chk({tag, " fcnt"},  32'(frame_cnt), 32'(fc));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    vec[0]  = mk(32'h9000_1234, 32'h0000_1234, 16'h1234, 16'h0000, 8'h00, 16'd1,  1'b0);
    vec[1]  = mk(32'h0100_0000, ODOL,          16'h1234, 16'h0000, 8'h00, 16'd2,  1'b0);
    vec[2]  = mk(32'h9100_BEEF, 32'h0000_BEEF, 16'h1234, 16'hBEEF, 8'h00, 16'd3,  1'b0);
    vec[3]  = mk(32'h92AB_CD5A, 32'h0000_005A, 16'h1234, 16'hBEEF, 8'h5A, 16'd4,  1'b0);
    vec[4]  = mk(32'h0000_0000, ID,            16'h1234, 16'hBEEF, 8'h5A, 16'd5,  1'b0);
    vec[5]  = mk(32'h0300_0000, 32'h0006_5AA5, 16'h1234, 16'hBEEF, 8'h5A, 16'd6,  1'b0);
    vec[6]  = mk(32'h9300_0000, 32'hDEAD_BEEF, 16'h1234, 16'hBEEF, 8'h5A, 16'd7,  1'b1);
    vec[7]  = mk(32'h7F00_0000, 32'hDEAD_BEEF, 16'h1234, 16'hBEEF, 8'h5A, 16'd8,  1'b0);
    vec[8]  = mk(32'hFF12_3456, 32'hDEAD_BEEF, 16'h1234, 16'hBEEF, 8'h5A, 16'd9,  1'b0);
    vec[9]  = mk(32'h0200_0000, ODOR,          16'h1234, 16'hBEEF, 8'h5A, 16'd10, 1'b0);
    vec[10] = mk(32'h1000_0000, 32'h0000_1234, 16'h1234, 16'hBEEF, 8'h5A, 16'd11, 1'b0);
    vec[11] = mk(32'h9000_0000, 32'h0000_0000, 16'h0000, 16'hBEEF, 8'h5A, 16'd12, 1'b0);
    vec[12] = mk(32'h9001_FFFF, 32'h0000_FFFF, 16'hFFFF, 16'hBEEF, 8'h5A, 16'd13, 1'b0);
    vec[13] = mk(32'h1100_0000, 32'h0000_BEEF, 16'hFFFF, 16'hBEEF, 8'h5A, 16'd14, 1'b0);
    vec[14] = mk(32'h1200_0000, 32'h0000_005A, 16'hFFFF, 16'hBEEF, 8'h5A, 16'd15, 1'b0);
    vec[15] = mk(32'h8000_0099, ID,            16'hFFFF, 16'hBEEF, 8'h5A, 16'd16, 1'b0);

    reset_n            = 1'b0;
    spi_if.spi_cs      = 1'b1;
    spi_if.spi_rx_word = '0;
    odo_l              = ODOL;
    odo_r              = ODOR;
    status_in          = STAT;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_regs("reset", ID, 16'h0, 16'h0, 8'h0, 16'd0);
    chk("reset odo_clear", 32'(odo_clear), 32'd0);
    chk("reset wdog", 32'(wdog_expired), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      exp_q.push_back(vec[i]);
      send_frame(vec[i].rx, 0);
      e = exp_q.pop_front();
      chk_regs($sformatf("vec%0d", i), e.tx, e.pl, e.pr, e.fl, e.fc);
      chk($sformatf("vec%0d odo_clear count", i), 32'(oc_hits), 32'(e.oc));
      if (e.oc) chk($sformatf("vec%0d odo_clear cycle", i), 32'(oc_pos), 32'd5);
    end

    // cs drops right after the frame edge: write stands, reply stays put.
    send_frame(32'h9000_0777, 2);
    chk_regs("csdrop", ID, 16'h0777, 16'hBEEF, 8'h5A, 16'd17);
    send_frame(32'h1000_0000, 0);
    chk_regs("after csdrop", 32'h0000_0777, 16'h0777, 16'hBEEF, 8'h5A, 16'd18);

    // Watchdog trips exactly WDOG cycles after the EXEC edge (5th rising edge).
    send_frame(32'h9000_0100, 0);
    chk("wd pwm_l set", 32'(pwm_l), 32'h0100);
    for (int k = 9; k <= 105; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 104) chk("wd not yet expired", 32'(wdog_expired), 32'd0);
    end
    chk("wd expired", 32'(wdog_expired), 32'd1);
    chk("wd pwm_l forced", 32'(pwm_l), 32'd0);
    chk("wd pwm_r forced", 32'(pwm_r), 32'd0);
    chk("wd flags kept", 32'(ctrl_flags), 32'h5A);
    send_frame(32'h1000_0000, 0);
    chk("wd cleared", 32'(wdog_expired), 32'd0);
    chk_regs("wd after", 32'h0, 16'h0, 16'h0, 8'h5A, 16'd20);

    // Reset in CAPTURE: no write, all back to reset values, next frame normal.
    @(negedge clk);
    spi_if.spi_cs      = 1'b0;
    spi_if.spi_rx_word = 32'h9000_4444;
    repeat (3) @(negedge clk);
    spi_if.spi_cs = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_regs("midreset", ID, 16'h0, 16'h0, 8'h0, 16'd0);
    chk("midreset wdog", 32'(wdog_expired), 32'd0);
    send_frame(32'h9000_0055, 0);
    chk_regs("post reset", 32'h0000_0055, 16'h0055, 16'h0, 8'h0, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
